fft_peak_tracker: RTL and testbench
===================================

# fft_peak_tracker

Downstream consumer of the FFT max-index stage: qualifies the raw per-frame peak bin index, locks onto it only after it repeats for a set number of consecutive frames, and converts the locked bin into a frequency in Hz. It holds the result for display/control logic and flags it stale when the FFT stops producing frames.

## Interface

- STABLE_COUNT, 4: consecutive identical accepted indices required to lock or change the lock (≥2).
- MIN_INDEX, 1: indices below this (DC bins) are rejected.
- BIN_HZ, 195: Hz per FFT bin (unsigned integer).
- FREQ_W, 16: width of the frequency output.
- TIMEOUT_CYCLES, 1000000: clk_in cycles without index_valid before declaring stale (≥2).

- clk_in  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- index_valid  in  1  one-cycle strobe: max_index holds a new frame result.
- max_index  in  8  unsigned peak bin index from the FFT stage.
- peak_index  out  8  locked bin index.
- peak_freq  out  FREQ_W  locked frequency, min(peak_index*BIN_HZ, 2^FREQ_W-1).
- peak_valid  out  1  high while a lock is held.
- peak_update  out  1  one-cycle pulse when peak_index/peak_freq change.
- stale  out  1  high after timeout, until next index_valid.

## Operation

- Reset: all outputs 0; candidate cand=0, match count cnt=0, timer=0, state SEARCH.
- States: SEARCH (no lock), LOCKED, STALE.
- Accepted sample: index_valid=1 and max_index ≥ MIN_INDEX. Rejected sample (index_valid=1, max_index < MIN_INDEX): cnt←0, cand unchanged; does not touch lock.
- On accepted sample: if max_index==cand and cnt≠0, cnt←min(cnt+1, STABLE_COUNT); else cand←max_index, cnt←1.
- Qualify event: accepted sample whose update makes cnt==STABLE_COUNT from STABLE_COUNT-1.
  - SEARCH: on qualify → load peak_index/peak_freq, peak_valid←1, pulse peak_update, go LOCKED.
  - LOCKED: on qualify with cand≠peak_index → reload, pulse peak_update. Qualify with cand==peak_index cannot occur without a prior change (count saturates; no repeat pulse).
  - Any state: timer reaches TIMEOUT_CYCLES-1 with no index_valid → STALE: stale←1, peak_valid←0, peak_index←0, peak_freq←0, cand←0, cnt←0. No peak_update pulse.
  - STALE: next index_valid (accepted or rejected) → stale←0, go SEARCH, sample processed normally that cycle.
- Timer: cleared on every index_valid (accepted or rejected); otherwise increments, saturating at TIMEOUT_CYCLES-1 while STALE.
- Frequency: full 8×32-bit product computed, saturated to FREQ_W bits all-ones on overflow.
- Index not matching current lock does not drop peak_valid; lock persists until replaced or timeout.

## Timing

- All outputs registered. Qualifying sample at edge N → new peak_index, peak_freq, peak_valid, peak_update visible after edge N (one-cycle latency); peak_update high exactly one cycle.
- Stale asserted the cycle after TIMEOUT_CYCLES consecutive cycles without index_valid.
- index_valid coincident with timeout cycle: index_valid wins; timer cleared, no stale.
- index_valid on back-to-back cycles supported; each is a separate sample.
- reset_n low mid-lock: outputs to 0 immediately (asynchronous), no pulse; restart in SEARCH after release.

## Test plan

Parameters STABLE_COUNT=4, MIN_INDEX=1, BIN_HZ=195, FREQ_W=16, TIMEOUT_CYCLES=100.
- Reset: hold reset_n=0 with random inputs → all outputs 0; release, no index_valid for 50 cycles → outputs stay 0.
- Lock: index 10 on 4 strobes → after 4th, peak_index=10, peak_freq=1950, peak_valid=1, one peak_update pulse; further 10s → no pulse.
- Glitch rejection: locked on 10, send 10,20,20,20,10 → lock stays 10, no pulse; then 20×4 → peak_index=20, peak_freq=3900, one pulse.
- DC reject / saturation: 0,0,0,0 → no lock; 7,7,0,7,7,7 → lock only at 4th consecutive 7 after the 0; with FREQ_W=8, index 2×4 → peak_freq=255.
- Timeout: locked on 10, no strobes 100 cycles → stale=1, peak_valid=0, peak_index=0, peak_freq=0; strobe index 5 → stale=0, lock at 5 after 4 strobes. Strobe in timeout cycle → stale stays 0.
- Async reset mid-lock: pull reset_n low between clock edges → outputs 0 before next edge.

Source files
------------

// File: rtl/fft_peak_tracker_if.sv
// fft_peak_tracker_if
//   Groups the frame-index input and the locked-peak result bus of the FFT
//   peak tracker.
//   master : drives index_valid/max_index, observes the peak result.
//   slave  : the tracker itself, consumes the index stream and drives results.
//   Signals:
//     index_valid  one-cycle strobe, max_index holds a new frame result
//     max_index    raw peak bin index from the FFT max-index stage
//     peak_index   locked bin index
//     peak_freq    locked frequency in Hz, saturated to FREQ_W bits
//     peak_valid   high while a lock is held
//     peak_update  one-cycle pulse when peak_index/peak_freq change
//     stale        high after the frame stream has stopped
interface fft_peak_tracker_if #(
  parameter int FREQ_W = 16
) ();
  logic              index_valid;
  logic [7:0]        max_index;
  logic [7:0]        peak_index;
  logic [FREQ_W-1:0] peak_freq;
  logic              peak_valid;
  logic              peak_update;
  logic              stale;

  modport master (
    output index_valid, max_index,
    input  peak_index, peak_freq, peak_valid, peak_update, stale
  );

  modport slave (
    input  index_valid, max_index,
    output peak_index, peak_freq, peak_valid, peak_update, stale
  );
endinterface

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker
//   Qualifies the per-frame FFT peak bin, locks onto it once it has repeated
//   STABLE_COUNT consecutive accepted frames, converts the locked bin to Hz
//   and flags the result stale when frames stop arriving.
//   Ports:
//     clk_in   system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      fft_peak_tracker_if.slave (index stream in, peak result out)
module fft_peak_tracker #(
  parameter int          STABLE_COUNT   = 4,
  parameter int          MIN_INDEX      = 1,
  parameter int unsigned BIN_HZ         = 195,
  parameter int          FREQ_W         = 16,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk_in,
  input  logic               reset_n,
  fft_peak_tracker_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_COUNT + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'(STABLE_COUNT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [39:0]      FREQ_MAX = (40'd1 << FREQ_W) - 40'd1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    STALE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        peak_index_q, peak_index_d;
  logic [FREQ_W-1:0] peak_freq_q, peak_freq_d;
  logic              peak_valid_q, peak_valid_d;
  logic              peak_update_q, peak_update_d;
  logic              stale_q, stale_d;

  logic              accepted_s;
  logic              match_s;
  logic              qualify_s;
  logic              timeout_s;
  logic [39:0]       prod_s;
  logic [FREQ_W-1:0] freq_s;
  state_t            eff_state_s;

  // Sample classification and the saturated frequency of the incoming index.
  always_comb begin
    accepted_s = bus.index_valid && (bus.max_index >= 8'(MIN_INDEX));
    match_s    = (bus.max_index == cand_q) && (cnt_q != '0);
    qualify_s  = accepted_s && match_s && (cnt_q == CNT_QUAL);
    // timeout only fires on an idle cycle, so a coincident strobe wins
    timeout_s  = !bus.index_valid && (timer_q == TMR_MAX);
    prod_s     = 40'(bus.max_index) * 40'(BIN_HZ);
    if (prod_s > FREQ_MAX) begin
      freq_s = '1;
    end else begin
      freq_s = prod_s[FREQ_W-1:0];
    end
    // a strobe while stale is handled as a normal SEARCH sample
    if ((state_q == STALE) && bus.index_valid) begin
      eff_state_s = SEARCH;
    end else begin
      eff_state_s = state_q;
    end
  end

  // Next-state logic: candidate tracking, lock FSM, idle timer, outputs.
  always_comb begin
    state_d       = eff_state_s;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    peak_index_d  = peak_index_q;
    peak_freq_d   = peak_freq_q;
    peak_valid_d  = peak_valid_q;
    peak_update_d = 1'b0;
    stale_d       = stale_q;

    if (bus.index_valid) begin
      timer_d = '0;
      stale_d = 1'b0;
    end else if (timer_q == TMR_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (timeout_s) begin
      state_d      = STALE;
      stale_d      = 1'b1;
      peak_valid_d = 1'b0;
      peak_index_d = 8'd0;
      peak_freq_d  = '0;
      cand_d       = 8'd0;
      cnt_d        = '0;
    end else begin
      if (accepted_s) begin
        if (match_s) begin
          if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          cand_d = bus.max_index;
          cnt_d  = CNT_W'(1);
        end
      end else if (bus.index_valid) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q;
      end

      case (eff_state_s)
        SEARCH: begin
          if (qualify_s) begin
            state_d       = LOCKED;
            peak_index_d  = bus.max_index;
            peak_freq_d   = freq_s;
            peak_valid_d  = 1'b1;
            peak_update_d = 1'b1;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // the count saturates, so re-qualifying the held bin needs a change first
          if (qualify_s && (bus.max_index != peak_index_q)) begin
            peak_index_d  = bus.max_index;
            peak_freq_d   = freq_s;
            peak_update_d = 1'b1;
          end else begin
            state_d = LOCKED;
          end
        end
        STALE: begin
          state_d = STALE;
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      cand_q        <= 8'd0;
      cnt_q         <= '0;
      timer_q       <= '0;
      peak_index_q  <= 8'd0;
      peak_freq_q   <= '0;
      peak_valid_q  <= 1'b0;
      peak_update_q <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      peak_index_q  <= peak_index_d;
      peak_freq_q   <= peak_freq_d;
      peak_valid_q  <= peak_valid_d;
      peak_update_q <= peak_update_d;
      stale_q       <= stale_d;
    end
  end

  assign bus.peak_index  = peak_index_q;
  assign bus.peak_freq   = peak_freq_q;
  assign bus.peak_valid  = peak_valid_q;
  assign bus.peak_update = peak_update_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// tb_fft_peak_tracker
//   Directed bench for fft_peak_tracker with STABLE_COUNT=4, MIN_INDEX=1,
//   BIN_HZ=195, TIMEOUT_CYCLES=100. A second instance with FREQ_W=8 sees the
//   same index stream to exercise frequency saturation.
module tb_fft_peak_tracker;

  logic       clk_in;
  logic       reset_n;
  logic       valid_s;
  logic [7:0] idx_s;
  int         n_vec;
  int         n_err;

  fft_peak_tracker_if #(.FREQ_W(16)) ifc ();
  fft_peak_tracker_if #(.FREQ_W(8))  ifc8 ();

  assign ifc.index_valid  = valid_s;
  assign ifc.max_index    = idx_s;
  assign ifc8.index_valid = valid_s;
  assign ifc8.max_index   = idx_s;

  fft_peak_tracker #(
    .STABLE_COUNT(4), .MIN_INDEX(1), .BIN_HZ(195), .FREQ_W(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .bus(ifc.slave)
  );

  fft_peak_tracker #(
    .STABLE_COUNT(4), .MIN_INDEX(1), .BIN_HZ(195), .FREQ_W(8), .TIMEOUT_CYCLES(100)
  ) dut8 (
    .clk_in(clk_in), .reset_n(reset_n), .bus(ifc8.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // one strobe; returns at the falling edge after the sampling edge
  task automatic strobe(input logic [7:0] idx);
    @(negedge clk_in);
    valid_s = 1'b1;
    idx_s   = idx;
    @(negedge clk_in);
    valid_s = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    valid_s = 1'b0;
    idx_s   = 8'd0;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic lock_on(input logic [7:0] idx);
    for (int i = 0; i < 4; i++) strobe(idx);
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_s = 1'($urandom_range(0, 1));
      idx_s   = 8'($urandom);
      @(negedge clk_in);
    end
    n_vec++;
    if ({ifc.peak_index, ifc.peak_freq, ifc.peak_valid, ifc.peak_update, ifc.stale} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_hold: outputs got %h expected 0",
               {ifc.peak_index, ifc.peak_freq, ifc.peak_valid, ifc.peak_update, ifc.stale});
    end
    valid_s = 1'b0;
    reset_n = 1'b1;
    idle(50);
    n_vec++;
    if ({ifc.peak_index, ifc.peak_freq, ifc.peak_valid, ifc.peak_update, ifc.stale} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_idle50: outputs got %h expected 0",
               {ifc.peak_index, ifc.peak_freq, ifc.peak_valid, ifc.peak_update, ifc.stale});
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(8'd10);
      n_vec++;
      if (ifc.peak_update !== (i == 3)) begin
        n_err++;
        $display("FAIL lock_pulse[%0d]: got %0d expected %0d", i, ifc.peak_update, (i == 3));
      end
      n_vec++;
      if (ifc.peak_valid !== (i == 3)) begin
        n_err++;
        $display("FAIL lock_valid[%0d]: got %0d expected %0d", i, ifc.peak_valid, (i == 3));
      end
    end
    n_vec++;
    if (ifc.peak_index !== 8'd10 || ifc.peak_freq !== 16'd1950) begin
      n_err++;
      $display("FAIL lock_value: got %0d/%0d expected 10/1950", ifc.peak_index, ifc.peak_freq);
    end
    idle(1);
    n_vec++;
    if (ifc.peak_update !== 1'b0) begin
      n_err++;
      $display("FAIL lock_pulse_width: got %0d expected 0", ifc.peak_update);
    end
    for (int i = 0; i < 3; i++) begin
      strobe(8'd10);
      n_vec++;
      if (ifc.peak_update !== 1'b0 || ifc.peak_valid !== 1'b1) begin
        n_err++;
        $display("FAIL lock_repeat[%0d]: upd/valid got %0d/%0d expected 0/1", i, ifc.peak_update, ifc.peak_valid);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] seq [5];
    seq = '{8'd10, 8'd20, 8'd20, 8'd20, 8'd10};
    apply_reset();
    lock_on(8'd10);
    for (int i = 0; i < 5; i++) begin
      strobe(seq[i]);
      n_vec++;
      if (ifc.peak_update !== 1'b0 || ifc.peak_index !== 8'd10) begin
        n_err++;
        $display("FAIL glitch[%0d]: upd/index got %0d/%0d expected 0/10", i, ifc.peak_update, ifc.peak_index);
      end
    end
    for (int i = 0; i < 4; i++) begin
      strobe(8'd20);
      n_vec++;
      if (ifc.peak_update !== (i == 3)) begin
        n_err++;
        $display("FAIL relock_pulse[%0d]: got %0d expected %0d", i, ifc.peak_update, (i == 3));
      end
    end
    n_vec++;
    if (ifc.peak_index !== 8'd20 || ifc.peak_freq !== 16'd3900 || ifc.peak_valid !== 1'b1) begin
      n_err++;
      $display("FAIL relock_value: got %0d/%0d/%0d expected 20/3900/1", ifc.peak_index, ifc.peak_freq, ifc.peak_valid);
    end
  endtask

  task automatic test_dc_reject();
    logic [7:0] seq [6];
    seq = '{8'd7, 8'd7, 8'd0, 8'd7, 8'd7, 8'd7};
    apply_reset();
    for (int i = 0; i < 4; i++) strobe(8'd0);
    n_vec++;
    if (ifc.peak_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dc_reject: peak_valid got %0d expected 0", ifc.peak_valid);
    end
    for (int i = 0; i < 6; i++) begin
      strobe(seq[i]);
      n_vec++;
      if (ifc.peak_valid !== 1'b0 || ifc.peak_update !== 1'b0) begin
        n_err++;
        $display("FAIL dc_break[%0d]: valid/upd got %0d/%0d expected 0/0", i, ifc.peak_valid, ifc.peak_update);
      end
    end
    strobe(8'd7);
    n_vec++;
    if (ifc.peak_valid !== 1'b1 || ifc.peak_update !== 1'b1 || ifc.peak_index !== 8'd7 || ifc.peak_freq !== 16'd1365) begin
      n_err++;
      $display("FAIL dc_lock7: got v%0d u%0d i%0d f%0d expected v1 u1 i7 f1365",
               ifc.peak_valid, ifc.peak_update, ifc.peak_index, ifc.peak_freq);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    lock_on(8'd2);
    n_vec++;
    if (ifc8.peak_freq !== 8'd255 || ifc8.peak_index !== 8'd2) begin
      n_err++;
      $display("FAIL sat_freq8: got %0d/%0d expected 2/255", ifc8.peak_index, ifc8.peak_freq);
    end
    n_vec++;
    if (ifc.peak_freq !== 16'd390) begin
      n_err++;
      $display("FAIL nosat_freq16: got %0d expected 390", ifc.peak_freq);
    end
    lock_on(8'd255);
    n_vec++;
    if (ifc.peak_freq !== 16'd49725 || ifc8.peak_freq !== 8'd255) begin
      n_err++;
      $display("FAIL freq255: got %0d/%0d expected 49725/255", ifc.peak_freq, ifc8.peak_freq);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    lock_on(8'd10);
    idle(99);
    n_vec++;
    if (ifc.stale !== 1'b0 || ifc.peak_valid !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: stale/valid got %0d/%0d expected 0/1", ifc.stale, ifc.peak_valid);
    end
    idle(1);
    n_vec++;
    if (ifc.stale !== 1'b1 || ifc.peak_valid !== 1'b0 || ifc.peak_index !== 8'd0 ||
        ifc.peak_freq !== 16'd0 || ifc.peak_update !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_stale: got s%0d v%0d i%0d f%0d u%0d expected s1 v0 i0 f0 u0",
               ifc.stale, ifc.peak_valid, ifc.peak_index, ifc.peak_freq, ifc.peak_update);
    end
    idle(20);
    n_vec++;
    if (ifc.stale !== 1'b1) begin
      n_err++;
      $display("FAIL stale_hold: got %0d expected 1", ifc.stale);
    end
    strobe(8'd5);
    n_vec++;
    if (ifc.stale !== 1'b0 || ifc.peak_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stale_exit: stale/valid got %0d/%0d expected 0/0", ifc.stale, ifc.peak_valid);
    end
    for (int i = 0; i < 3; i++) strobe(8'd5);
    n_vec++;
    if (ifc.peak_valid !== 1'b1 || ifc.peak_index !== 8'd5 || ifc.peak_freq !== 16'd975 || ifc.peak_update !== 1'b1) begin
      n_err++;
      $display("FAIL stale_relock: got v%0d i%0d f%0d u%0d expected v1 i5 f975 u1",
               ifc.peak_valid, ifc.peak_index, ifc.peak_freq, ifc.peak_update);
    end
  endtask

  task automatic test_timeout_race();
    apply_reset();
    lock_on(8'd10);
    idle(98);
    strobe(8'd0);
    n_vec++;
    if (ifc.stale !== 1'b0 || ifc.peak_valid !== 1'b1 || ifc.peak_index !== 8'd10) begin
      n_err++;
      $display("FAIL timeout_race: got s%0d v%0d i%0d expected s0 v1 i10", ifc.stale, ifc.peak_valid, ifc.peak_index);
    end
    idle(99);
    n_vec++;
    if (ifc.stale !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_restart: stale got %0d expected 0", ifc.stale);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      valid_s = 1'b1;
      idx_s   = 8'd30;
      @(negedge clk_in);
      n_vec++;
      if (ifc.peak_update !== (i == 3)) begin
        n_err++;
        $display("FAIL b2b_pulse[%0d]: got %0d expected %0d", i, ifc.peak_update, (i == 3));
      end
    end
    valid_s = 1'b0;
    n_vec++;
    if (ifc.peak_index !== 8'd30 || ifc.peak_freq !== 16'd5850) begin
      n_err++;
      $display("FAIL b2b_value: got %0d/%0d expected 30/5850", ifc.peak_index, ifc.peak_freq);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    lock_on(8'd10);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ifc.peak_index, ifc.peak_freq, ifc.peak_valid, ifc.peak_update, ifc.stale} !== 27'd0) begin
      n_err++;
      $display("FAIL async_reset: outputs got %h expected 0",
               {ifc.peak_index, ifc.peak_freq, ifc.peak_valid, ifc.peak_update, ifc.stale});
    end
    idle(1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) strobe(8'd10);
    n_vec++;
    if (ifc.peak_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_restart: peak_valid got %0d expected 0", ifc.peak_valid);
    end
    strobe(8'd10);
    n_vec++;
    if (ifc.peak_valid !== 1'b1 || ifc.peak_update !== 1'b1) begin
      n_err++;
      $display("FAIL async_relock: valid/upd got %0d/%0d expected 1/1", ifc.peak_valid, ifc.peak_update);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    valid_s = 1'b0;
    idx_s   = 8'd0;
    reset_n = 1'b0;
    test_reset();
    test_lock();
    test_glitch();
    test_dc_reject();
    test_saturation();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
